// File: rtl/map_pkg.sv
// Shared map geometry, tile codes and the column-to-bit-position helper.
package map_pkg;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int TILE_W   = 4;
  localparam int ROW_W    = 160;

  typedef enum logic [3:0] {
    T_EMPTY  = 4'd0,
    T_WALL   = 4'd1,
    T_PILL   = 4'd2,
    T_PACMAN = 4'd3,
    T_GHOST1 = 4'd4,
    T_GHOST2 = 4'd5,
    T_GHOST3 = 4'd6,
    T_GHOST4 = 4'd7,
    T_POWER  = 4'd8
  } tile_t;

  // Column 0 sits at the MSB end of the row word.
  function automatic logic [7:0] tile_lsb(input logic [5:0] x);
    return 8'(ROW_W - TILE_W * (int'(x) + 1));
  endfunction
endpackage

// File: rtl/map_tile_mover_tile_splice.sv
// Replaces one 4-bit tile field inside a map row word and returns the
// code that was there before. Out-of-range columns pass the word through.
module tile_splice
  import map_pkg::*;
#(
  parameter int COLS = MAP_COLS
) (
  input  logic [ROW_W-1:0]  word_in,
  input  logic [5:0]        col,
  input  logic [TILE_W-1:0] code,
  output logic [ROW_W-1:0]  word_out,
  output logic [TILE_W-1:0] old_code
);

  logic [7:0] lsb;

  // Field replace; every other bit of the row is carried through unchanged.
  always_comb begin
    lsb      = tile_lsb(col);
    word_out = word_in;
    old_code = '0;
    if (col < 6'(COLS)) begin
      old_code                 = word_in[lsb +: TILE_W];
      word_out[lsb +: TILE_W]  = code;
    end
  end

endmodule

// File: rtl/map_tile_mover.sv
// Read-modify-write engine on map RAM port B: clears the vacated tile with
// the fill code, writes the sprite code at the destination, and reports the
// code previously found at the destination.
module map_tile_mover #(
  parameter int RD_LAT   = 1,
  parameter int MAP_COLS = map_pkg::MAP_COLS,
  parameter int MAP_ROWS = map_pkg::MAP_ROWS
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [5:0]               req_old_x,
  input  logic [4:0]               req_old_y,
  input  logic [5:0]               req_new_x,
  input  logic [4:0]               req_new_y,
  input  logic [3:0]               req_tile,
  input  logic [3:0]               req_fill,
  output logic [4:0]               ram_addr,
  output logic [map_pkg::ROW_W-1:0] ram_wrdata,
  output logic                     ram_wren,
  input  logic [map_pkg::ROW_W-1:0] ram_q,
  output logic                     done,
  output logic [3:0]               hit_tile,
  output logic                     err
);
  import map_pkg::*;

  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_OLD, S_WT_OLD, S_WR_OLD, S_RD_NEW, S_WT_NEW, S_WR_NEW, S_DONE
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt, cnt_n;
  logic [5:0]      old_x, new_x;
  logic [4:0]      old_y, new_y;
  logic [3:0]      tile, fill;
  logic            take, bad, same;
  logic [4:0]      addr_n;
  logic            wren_n, done_n, err_n;
  logic [5:0]      sp_col;
  logic [3:0]      sp_code, sp_old;
  logic [ROW_W-1:0] sp_word;

  assign take = req_valid & req_ready;
  assign bad  = (req_old_x > 6'(MAP_COLS - 1)) | (req_new_x > 6'(MAP_COLS - 1)) |
                (req_old_y > 5'(MAP_ROWS - 1)) | (req_new_y > 5'(MAP_ROWS - 1));
  assign same = (req_old_x == req_new_x) && (req_old_y == req_new_y);

  // Next state plus next values of the registered RAM/status outputs.
  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    addr_n = ram_addr;
    err_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          if (bad) begin
            nxt   = S_DONE;
            err_n = 1'b1;
          end else if (same) begin
            nxt    = S_RD_NEW;
            addr_n = req_new_y;
          end else begin
            nxt    = S_RD_OLD;
            addr_n = req_old_y;
          end
        end
      end
      S_RD_OLD: begin
        cnt_n = CW'(1);
        nxt   = (RD_LAT > 1) ? S_WT_OLD : S_WR_OLD;
      end
      S_WT_OLD: begin
        if (cnt == CW'(RD_LAT - 1)) nxt = S_WR_OLD;
        else cnt_n = cnt + CW'(1);
      end
      S_WR_OLD: begin
        nxt    = S_RD_NEW;
        addr_n = new_y;
      end
      S_RD_NEW: begin
        cnt_n = CW'(1);
        nxt   = (RD_LAT > 1) ? S_WT_NEW : S_WR_NEW;
      end
      S_WT_NEW: begin
        if (cnt == CW'(RD_LAT - 1)) nxt = S_WR_NEW;
        else cnt_n = cnt + CW'(1);
      end
      S_WR_NEW: nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    wren_n = (nxt == S_WR_OLD) || (nxt == S_WR_NEW);
    done_n = (nxt == S_DONE);
  end

  // State register and registered outputs; hit_tile captured while WR_NEW reads ram_q.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      ram_addr  <= '0;
      ram_wren  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      hit_tile  <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_n;
      req_ready <= (nxt == S_IDLE);
      ram_addr  <= addr_n;
      ram_wren  <= wren_n;
      done      <= done_n;
      err       <= err_n;
      if (state == S_WR_NEW) hit_tile <= sp_old;
    end
  end

  // Request fields held for the whole move.
  always_ff @(posedge CLOCK_50) begin
    if (take) begin
      old_x <= req_old_x;
      old_y <= req_old_y;
      new_x <= req_new_x;
      new_y <= req_new_y;
      tile  <= req_tile;
      fill  <= req_fill;
    end
  end

  // One splicer shared by both write phases.
  assign sp_col  = (state == S_WR_NEW) ? new_x : old_x;
  assign sp_code = (state == S_WR_NEW) ? tile  : fill;

  tile_splice #(.COLS(MAP_COLS)) u_splice (
    .word_in  (ram_q),
    .col      (sp_col),
    .code     (sp_code),
    .word_out (sp_word),
    .old_code (sp_old)
  );

  assign ram_wrdata = ram_wren ? sp_word : '0;

endmodule

// File: tb/tb_map_tile_mover.sv
// Bench for map_tile_mover: behavioural map RAM with configurable read
// latency and a move-level reference model of the tile map.
module tb_map_tile_mover;
  import map_pkg::*;

  localparam int RD_LAT = 1;

  logic         CLOCK_50;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_old_x, req_new_x;
  logic [4:0]   req_old_y, req_new_y;
  logic [3:0]   req_tile, req_fill;
  logic [4:0]   ram_addr;
  logic [159:0] ram_wrdata;
  logic         ram_wren;
  logic [159:0] ram_q;
  logic         done;
  logic [3:0]   hit_tile;
  logic         err;

  map_tile_mover #(.RD_LAT(RD_LAT)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_old_x  (req_old_x),
    .req_old_y  (req_old_y),
    .req_new_x  (req_new_x),
    .req_new_y  (req_new_y),
    .req_tile   (req_tile),
    .req_fill   (req_fill),
    .ram_addr   (ram_addr),
    .ram_wrdata (ram_wrdata),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .done       (done),
    .hit_tile   (hit_tile),
    .err        (err)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Map RAM port B model
  logic [159:0] mem     [32];
  logic [159:0] ref_mem [32];
  logic [159:0] qpipe   [RD_LAT];
  int           wlog[$];
  logic [3:0]   exp_hit;
  int           n_checks = 0;
  int           n_fail   = 0;

  always @(posedge CLOCK_50) begin
    for (int i = RD_LAT - 1; i > 0; i--) qpipe[i] <= qpipe[i-1];
    qpipe[0] <= mem[ram_addr];
    if (ram_wren) begin
      mem[ram_addr] <= ram_wrdata;
      wlog.push_back(int'(ram_addr));
    end
  end
  assign ram_q = qpipe[RD_LAT-1];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_map(input string tag);
    int diff = 0;
    for (int r = 0; r < 32; r++) if (mem[r] !== ref_mem[r]) diff++;
    check(tag, diff, 0);
  endtask

  // Move-level model: what the map and status should look like after one request.
  task automatic model_req(input int ox, input int oy, input int nx, input int ny,
                           input logic [3:0] t, input logic [3:0] f,
                           output int lat, output logic e, output int nwr,
                           output int row0, output int row1);
    e    = (ox > 39) || (nx > 39) || (oy > 29) || (ny > 29);
    nwr  = 0;
    row0 = -1;
    row1 = -1;
    if (e) begin
      lat = 1;
    end else if (ox == nx && oy == ny) begin
      lat     = RD_LAT + 2;
      exp_hit = ref_mem[ny][159-4*nx -: 4];
      ref_mem[ny][159-4*nx -: 4] = t;
      nwr  = 1;
      row0 = ny;
    end else begin
      lat = 2 * RD_LAT + 3;
      ref_mem[oy][159-4*ox -: 4] = f;
      exp_hit = ref_mem[ny][159-4*nx -: 4];
      ref_mem[ny][159-4*nx -: 4] = t;
      nwr  = 2;
      row0 = oy;
      row1 = ny;
    end
  endtask

  task automatic drive_fields(input int ox, input int oy, input int nx, input int ny,
                              input logic [3:0] t, input logic [3:0] f);
    req_old_x = 6'(ox);
    req_old_y = 5'(oy);
    req_new_x = 6'(nx);
    req_new_y = 5'(ny);
    req_tile  = t;
    req_fill  = f;
  endtask

  task automatic run_req(input string tag, input int ox, input int oy, input int nx, input int ny,
                         input logic [3:0] t, input logic [3:0] f);
    int lat, nwr, row0, row1, k;
    logic e;
    model_req(ox, oy, nx, ny, t, f, lat, e, nwr, row0, row1);
    @(negedge CLOCK_50);
    drive_fields(ox, oy, nx, ny, t, f);
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge CLOCK_50);
      k++;
    end
    check({tag, "_ready"}, req_ready, 1'b1);
    wlog.delete();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    k = 1;
    while (!done && k < 40) begin
      @(negedge CLOCK_50);
      k++;
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_err"}, err, e);
    check({tag, "_hit"}, hit_tile, exp_hit);
    check({tag, "_wr_count"}, wlog.size(), nwr);
    check({tag, "_wr_row0"}, (wlog.size() > 0) ? wlog[0] : -1, row0);
    check({tag, "_wr_row1"}, (wlog.size() > 1) ? wlog[1] : -1, row1);
    @(negedge CLOCK_50);
    check({tag, "_done_pulse"}, {done, err}, 2'b00);
    check({tag, "_ready_after"}, req_ready, 1'b1);
    compare_map({tag, "_map"});
  endtask

  logic [159:0] exp5;
  int qox[3], qoy[3], qnx[3], qny[3];
  logic [3:0] qt[3], qf[3], qhit[3];
  int acc_t[3], done_t[3];

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    drive_fields(0, 0, 0, 0, 4'h0, 4'h0);
    exp_hit   = 4'h0;
    for (int r = 0; r < 32; r++) begin
      mem[r]     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      ref_mem[r] = mem[r];
    end
    mem[5]     = {40{4'h2}};
    ref_mem[5] = mem[5];

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_ready", req_ready, 1'b0);
    check("rst_wren", ram_wren, 1'b0);
    check("rst_addr", ram_addr, 5'd0);
    check("rst_wrdata", ram_wrdata, 160'd0);
    check("rst_status", {done, err, hit_tile}, 6'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("rst_ready_after", req_ready, 1'b1);

    // 1: pacman steps right along a row of pills
    run_req("t1", 3, 5, 4, 5, T_PACMAN, T_EMPTY);
    exp5 = {40{4'h2}};
    exp5[159-12 -: 4] = 4'h0;
    exp5[159-16 -: 4] = 4'h3;
    check("t1_row5", mem[5], exp5);
    check("t1_hit_pill", hit_tile, 4'h2);

    // 2: move across rows
    run_req("t2", 10, 2, 10, 3, T_PACMAN, T_EMPTY);

    // 3: same tile, single write at the MSB field
    run_req("t3", 0, 0, 0, 0, T_GHOST1, T_EMPTY);
    check("t3_field", mem[0][159:156], 4'h4);

    // 4: destination column out of range
    run_req("t4", 5, 5, 40, 5, T_PACMAN, T_EMPTY);

    // 5: reset while the destination row is being read
    ref_mem[7][159-4*3 -: 4] = 4'h0;
    @(negedge CLOCK_50);
    drive_fields(3, 7, 20, 9, T_PACMAN, T_EMPTY);
    req_valid = 1'b1;
    check("t5_ready", req_ready, 1'b1);
    wlog.delete();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    repeat (RD_LAT + 1) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("t5_wren", ram_wren, 1'b0);
    check("t5_addr", ram_addr, 5'd0);
    check("t5_ready_in_rst", req_ready, 1'b0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("t5_ready_post", req_ready, 1'b1);
    check("t5_hit_cleared", hit_tile, 4'h0);
    check("t5_partial_writes", wlog.size(), 1);
    exp_hit = 4'h0;
    compare_map("t5_map");
    run_req("t5_next", 20, 9, 21, 9, T_PACMAN, T_EMPTY);

    // 6: three queued requests with req_valid held high
    for (int i = 0; i < 3; i++) begin
      qox[i] = $urandom_range(0, 39);
      qoy[i] = $urandom_range(0, 29);
      do begin
        qnx[i] = $urandom_range(0, 39);
        qny[i] = $urandom_range(0, 29);
      end while (qnx[i] == qox[i] && qny[i] == qoy[i]);
      qt[i] = 4'($urandom_range(0, 15));
      qf[i] = 4'($urandom_range(0, 15));
      begin
        int lat, nwr, r0, r1;
        logic e;
        model_req(qox[i], qoy[i], qnx[i], qny[i], qt[i], qf[i], lat, e, nwr, r0, r1);
        qhit[i] = exp_hit;
      end
    end
    begin
      int idx = 0, acc = 0, nd = 0, t = 0;
      bit acc_now;
      wlog.delete();
      @(negedge CLOCK_50);
      drive_fields(qox[0], qoy[0], qnx[0], qny[0], qt[0], qf[0]);
      req_valid = 1'b1;
      for (int c = 0; c < 300 && nd < 3; c++) begin
        acc_now = req_valid && req_ready;
        @(posedge CLOCK_50);
        t++;
        if (acc_now) begin
          if (acc < 3) acc_t[acc] = t;
          acc++;
        end
        @(negedge CLOCK_50);
        if (acc_now) begin
          idx++;
          if (idx < 3) drive_fields(qox[idx], qoy[idx], qnx[idx], qny[idx], qt[idx], qf[idx]);
          else req_valid = 1'b0;
        end
        if (done) begin
          if (nd < 3) begin
            done_t[nd] = t;
            check("q_hit", hit_tile, qhit[nd]);
            check("q_err", err, 1'b0);
          end
          nd++;
        end
      end
      req_valid = 1'b0;
      check("q_done_count", nd, 3);
      check("q_accepts", acc, 3);
      if (nd == 3 && acc == 3) begin
        check("q_latency", done_t[0] - acc_t[0] + 1, 2 * RD_LAT + 3);
        for (int i = 1; i < 3; i++) begin
          check("q_done_spacing", done_t[i] - done_t[i-1], 2 * RD_LAT + 4);
          check("q_accept_spacing", acc_t[i] - acc_t[i-1], 2 * RD_LAT + 4);
        end
      end
      check("q_writes", wlog.size(), 6);
      @(negedge CLOCK_50);
      compare_map("q_map");
    end

    // Randomized moves, including same-tile and out-of-range requests
    for (int i = 0; i < 16; i++) begin
      int ox, oy, nx, ny;
      ox = $urandom_range(0, 41);
      oy = $urandom_range(0, 30);
      if ($urandom_range(0, 3) == 0) begin
        nx = ox;
        ny = oy;
      end else begin
        nx = $urandom_range(0, 41);
        ny = $urandom_range(0, 30);
      end
      run_req("rnd", ox, oy, nx, ny, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
